// File: rtl/tcdm_demux_pkg.sv
// Shared types and width helpers for the N-way TCDM demultiplexer.
// Port modes and destination sizing used by the top, tracker and interface.
package tcdm_demux_pkg;

    typedef enum logic {
        PORT_TCDM = 1'b0,
        PORT_SRAM = 1'b1
    } port_mode_e;

    function automatic int cnt_width(input int max_outst);
        return (max_outst < 1) ? 1 : $clog2(max_outst + 1);
    endfunction

    function automatic int sel_width(input int nb);
        return (nb < 2) ? 1 : $clog2(nb);
    endfunction

    // One extra bit so the error destination (index NB_MASTER) always fits
    function automatic int dest_width(input int nb);
        return sel_width(nb) + 1;
    endfunction

    function automatic port_mode_e port_mode(input logic mask_bit);
        return mask_bit ? PORT_SRAM : PORT_TCDM;
    endfunction

endpackage

// File: rtl/tcdm_demux_n_if.sv
// Slave stream plus flattened per-port master bundle of the TCDM demux.
// The slave modport is the demux view, master is the surrounding system.
interface tcdm_demux_n_if #(
    parameter int NB_MASTER = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
);
    import tcdm_demux_pkg::*;

    localparam int BE_W  = DATA_W / 8;
    localparam int SEL_W = sel_width(NB_MASTER);
    localparam int CNT_W = cnt_width(MAX_OUTST);

    logic [SEL_W-1:0]            port_sel_i;
    logic                        s_req_i;
    logic [ADDR_W-1:0]           s_add_i;
    logic                        s_wen_i;
    logic [DATA_W-1:0]           s_wdata_i;
    logic [BE_W-1:0]             s_be_i;
    logic                        s_gnt_o;
    logic                        s_r_valid_o;
    logic [DATA_W-1:0]           s_r_rdata_o;
    logic                        s_r_err_o;
    logic [NB_MASTER-1:0]        m_req_o;
    logic [NB_MASTER*ADDR_W-1:0] m_add_o;
    logic [NB_MASTER-1:0]        m_wen_o;
    logic [NB_MASTER*DATA_W-1:0] m_wdata_o;
    logic [NB_MASTER*BE_W-1:0]   m_be_o;
    logic [NB_MASTER-1:0]        m_gnt_i;
    logic [NB_MASTER-1:0]        m_r_valid_i;
    logic [NB_MASTER*DATA_W-1:0] m_r_rdata_i;
    logic [CNT_W-1:0]            outst_cnt_o;

    modport slave (
        input  port_sel_i, s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
        input  m_gnt_i, m_r_valid_i, m_r_rdata_i,
        output s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_err_o,
        output m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
        output outst_cnt_o
    );

    modport master (
        output port_sel_i, s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
        output m_gnt_i, m_r_valid_i, m_r_rdata_i,
        input  s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_err_o,
        input  m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
        input  outst_cnt_o
    );

endinterface

// File: rtl/tcdm_demux_tracker.sv
// Outstanding-request tracker: counter, destination lock and local valids.
// Responses stay in order because the destination only changes when drained.
module tcdm_demux_tracker
    import tcdm_demux_pkg::*;
#(
    parameter int                   NB_MASTER = 2,
    parameter int                   MAX_OUTST = 4,
    parameter logic [NB_MASTER-1:0] SRAM_MASK = NB_MASTER'(2'b10),
    localparam int                  SEL_W     = sel_width(NB_MASTER),
    localparam int                  CNT_W     = cnt_width(MAX_OUTST),
    localparam int                  DEST_W    = dest_width(NB_MASTER)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [SEL_W-1:0]     i_sel,
    input  logic                 i_sel_gnt,
    input  logic [NB_MASTER-1:0] i_r_valid,
    output logic                 o_can_issue,
    output logic                 o_gnt,
    output logic                 o_rsp,
    output logic                 o_err,
    output logic [DEST_W-1:0]    o_dest,
    output logic [CNT_W-1:0]     o_cnt
);

    typedef logic [DEST_W-1:0] dest_t;

    localparam dest_t            ERR     = dest_t'(NB_MASTER);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dest_t            r_dest;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sram_vld;
    logic             r_err_vld;

    dest_t            w_sel_dest;
    logic             w_in_range;
    logic             w_sel_sram;
    logic             w_rsp;
    logic             w_rsp_now;
    logic             w_can_issue;
    logic             w_gnt;
    logic             w_dec;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_in_range = 1'b0;
        w_sel_sram = 1'b0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_in_range = 1'b1;
                w_sel_sram = (port_mode(SRAM_MASK[i]) == PORT_SRAM);
            end
        end
        w_sel_dest = w_in_range ? dest_t'(i_sel) : ERR;
    end

    always_comb begin
        w_rsp = (r_dest == ERR) ? r_err_vld : 1'b0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (r_dest == dest_t'(i)) begin
                w_rsp = (port_mode(SRAM_MASK[i]) == PORT_SRAM) ?
                        r_sram_vld : i_r_valid[i];
            end
        end
    end

    // A full counter blocks issue even if a response drains this cycle
    always_comb begin
        w_rsp_now   = w_rsp & (r_cnt == CNT_ONE);
        w_can_issue = (r_cnt < CNT_MAX) &
                      ((r_cnt == '0) | (w_sel_dest == r_dest) | w_rsp_now);
        w_gnt       = w_can_issue & i_req & (w_in_range ? i_sel_gnt : 1'b1);
        w_dec       = w_rsp & (r_cnt != '0);
        w_cnt_nxt   = r_cnt + CNT_W'(w_gnt) - CNT_W'(w_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_dest     <= '0;
            r_sram_vld <= 1'b0;
            r_err_vld  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_sram_vld <= w_gnt & w_in_range & w_sel_sram;
            r_err_vld  <= w_gnt & ~w_in_range;
            if (w_gnt) begin
                r_dest <= w_sel_dest;
            end
        end
    end

    a_no_stray_rsp : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_rsp && (r_cnt == '0))
    );

    a_cnt_bound : assert property (
        @(posedge clk) disable iff (!rst_n) r_cnt <= CNT_MAX
    );

    assign o_can_issue = w_can_issue;
    assign o_gnt       = w_gnt;
    assign o_rsp       = w_rsp;
    assign o_err       = r_err_vld & (r_dest == ERR);
    assign o_dest      = r_dest;
    assign o_cnt       = r_cnt;

endmodule

// File: rtl/tcdm_demux_n.sv
// N-way TCDM demux: routes one slave stream to NB_MASTER ports.
// Holds request isolation and response muxing; ordering lives in the tracker.
module tcdm_demux_n
    import tcdm_demux_pkg::*;
#(
    parameter int                   NB_MASTER = 2,
    parameter int                   ADDR_W    = 32,
    parameter int                   DATA_W    = 32,
    parameter int                   MAX_OUTST = 4,
    parameter logic [NB_MASTER-1:0] SRAM_MASK = NB_MASTER'(2'b10)
) (
    input  logic          clk,
    input  logic          rst_n,
    tcdm_demux_n_if.slave bus
);

    localparam int BE_W   = DATA_W / 8;
    localparam int SEL_W  = sel_width(NB_MASTER);
    localparam int CNT_W  = cnt_width(MAX_OUTST);
    localparam int DEST_W = dest_width(NB_MASTER);

    typedef logic [DEST_W-1:0] dest_t;

    logic             w_sel_gnt;
    logic             w_can_issue;
    logic             w_gnt;
    logic             w_rsp;
    logic             w_err;
    dest_t            w_dest;
    logic [CNT_W-1:0] w_cnt;

    always_comb begin
        w_sel_gnt = 1'b0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (bus.port_sel_i == SEL_W'(i)) begin
                w_sel_gnt = (port_mode(SRAM_MASK[i]) == PORT_SRAM) ?
                            1'b1 : bus.m_gnt_i[i];
            end
        end
    end

    tcdm_demux_tracker #(
        .NB_MASTER (NB_MASTER),
        .MAX_OUTST (MAX_OUTST),
        .SRAM_MASK (SRAM_MASK)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (bus.s_req_i),
        .i_sel       (bus.port_sel_i),
        .i_sel_gnt   (w_sel_gnt),
        .i_r_valid   (bus.m_r_valid_i),
        .o_can_issue (w_can_issue),
        .o_gnt       (w_gnt),
        .o_rsp       (w_rsp),
        .o_err       (w_err),
        .o_dest      (w_dest),
        .o_cnt       (w_cnt)
    );

    // Unselected ports see all-zero operands
    always_comb begin
        bus.m_req_o   = '0;
        bus.m_add_o   = '0;
        bus.m_wen_o   = '0;
        bus.m_wdata_o = '0;
        bus.m_be_o    = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (bus.s_req_i && (bus.port_sel_i == SEL_W'(i))) begin
                bus.m_req_o[i]                    = w_can_issue;
                bus.m_add_o[i*ADDR_W +: ADDR_W]   = bus.s_add_i;
                bus.m_wen_o[i]                    = bus.s_wen_i;
                bus.m_wdata_o[i*DATA_W +: DATA_W] = bus.s_wdata_i;
                bus.m_be_o[i*BE_W +: BE_W]        = bus.s_be_i;
            end
        end
    end

    always_comb begin
        bus.s_r_rdata_o = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (w_rsp && (w_dest == dest_t'(i))) begin
                bus.s_r_rdata_o = bus.m_r_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.s_gnt_o     = w_gnt;
    assign bus.s_r_valid_o = w_rsp;
    assign bus.s_r_err_o   = w_err;
    assign bus.outst_cnt_o = w_cnt;

endmodule
